// File: rtl/cam_pixel_capture.sv
// cam_pixel_capture: RGB444 byte-pair camera capture with raster coordinates; define CAPTURE_STARTUP_SKIP_EN to drop the first SKIP_FRAMES frames after reset
module cam_pixel_capture #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned SKIP_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  din,
  output logic [11:0] pixel,
  output logic        pixel_valid,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        frame_done,
  output logic        line_err
);
  typedef enum logic [1:0] {SYNC, VBLANK, ACTIVE, BYTE1} state_t;
`ifdef CAPTURE_STARTUP_SKIP_EN
  localparam int unsigned SKIP = SKIP_FRAMES;
`else
  localparam int unsigned SKIP = SKIP_FRAMES & 32'd0;
`endif
  localparam int SW = SKIP > 3 ? $clog2(SKIP + 1) : 2;
  state_t        state;
  logic [3:0]    r;
  logic [9:0]    col;
  logic [8:0]    row;
  logic          href_q, emitted, live, frame_end, in_range;
  logic [SW-1:0] skipped;
  assign frame_end = (state == ACTIVE || state == BYTE1) && vsync;
  assign live      = (SKIP == 0) || (32'(skipped) >= SKIP);
  assign in_range  = (32'(col) < H_ACTIVE) && (32'(row) < V_ACTIVE);
  // count completed frames until the startup skip window has passed; stops (saturates) once live
  always_ff @(posedge clk or negedge reset)
    if (!reset) skipped <= '0;
    else if (frame_end && !live) skipped <= skipped + 1'b1;
  // framing state machine, pixel assembly and registered outputs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= SYNC;
      r           <= '0;
      col         <= '0;
      row         <= '0;
      href_q      <= 1'b0;
      emitted     <= 1'b0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      href_q      <= href;
      case (state)
        SYNC: if (vsync) state <= VBLANK;
        VBLANK:
          if (!vsync) begin
            state    <= ACTIVE;
            col      <= '0;
            row      <= '0;
            line_err <= 1'b0;
            emitted  <= 1'b0;
          end
        ACTIVE, BYTE1:
          if (vsync) begin
            state      <= VBLANK;
            frame_done <= emitted;
            emitted    <= 1'b0;
          end else if (href) begin
            if (state == ACTIVE) begin
              r     <= din[3:0];
              state <= BYTE1;
            end else begin
              state <= ACTIVE;
              col   <= (col == 10'h3ff) ? col : col + 10'd1;
              if (in_range && live) begin
                pixel_valid <= 1'b1;
                pixel       <= {r, din};
                x           <= col;
                y           <= row;
                emitted     <= 1'b1;
              end
            end
          end else begin
            if (href_q) begin
              col <= '0;
              row <= (row == 9'h1ff) ? row : row + 9'd1;
            end
            if (state == BYTE1) begin
              line_err <= 1'b1;
              state    <= ACTIVE;
            end
          end
        default: state <= SYNC;
      endcase
    end
endmodule

// File: doc/cam_pixel_capture.md
# cam_pixel_capture

Upstream front end of the edge-detect pipeline. Samples the camera's 8-bit RGB444 byte stream (vsync/href framing), assembles byte pairs into 12-bit `{R,G,B}` pixels and emits them with a one-cycle valid strobe plus raster coordinates. Output feeds the 3x3 convolution window stage, whose line buffers assume exactly `H_ACTIVE` pixels per line.

## Interface
- `H_ACTIVE`, 640, pixels per active line; extra pixels in a line are dropped
- `V_ACTIVE`, 480, lines per frame; extra lines are dropped
- `SKIP_FRAMES`, 2, frames discarded after reset (only with `CAPTURE_STARTUP_SKIP_EN`)

- `clk` in 1: camera pixel clock; all inputs synchronous to it
- `reset` in 1: asynchronous, active-low; clears all state
- `vsync` in 1: high during vertical blanking
- `href` in 1: high while line bytes are valid
- `din` in 8: camera data byte
- `pixel` out 12: `{R[3:0],G[3:0],B[3:0]}`
- `pixel_valid` out 1: one-cycle strobe, `pixel`/`x`/`y` valid
- `x` out 10: column of current pixel, 0..H_ACTIVE-1
- `y` out 9: row of current pixel, 0..V_ACTIVE-1
- `frame_done` out 1: one-cycle pulse when a frame ends (vsync rising) after any pixel was emitted
- `line_err` out 1: sticky; set on odd byte count in a line, cleared at next frame start

## Operation
- States: `SYNC` (wait for first vsync rise), `VBLANK` (vsync high), `ACTIVE` (vsync low, between lines), `BYTE1` (first byte latched, waiting for second).
- `SYNC` -> `VBLANK` on `vsync`=1. Capture never starts mid-frame.
- `VBLANK` -> `ACTIVE` on `vsync`=0; clear line/col counters and `line_err`.
- `ACTIVE`: on `href`=1 latch `din[3:0]` as R, go `BYTE1`.
- `BYTE1`: on `href`=1 form `pixel={R, din}`; if col < H_ACTIVE and row < V_ACTIVE, pulse `pixel_valid`; increment col (saturate at 1023); go `ACTIVE`. On `href`=0 in `BYTE1`: discard R, set `line_err`, go `ACTIVE`.
- `href` falling edge (from either state): col <= 0, row += 1 (saturate at 511).
- `vsync`=1 in `ACTIVE`/`BYTE1`: abort, go `VBLANK`; pending byte discarded; `frame_done` pulses if ≥1 pixel emitted this frame.
- Byte order fixed: first byte `{xxxx,R}`, second `{G,B}`. Upper nibble of first byte ignored.
- Short lines/frames: emitted as-is; no padding.

## Timing
- Reset values: `pixel`=0, `pixel_valid`=0, `x`=0, `y`=0, `frame_done`=0, `line_err`=0, state `SYNC`.
- All outputs registered. `pixel_valid` asserts on the edge after the cycle in which the second byte is sampled (latency 1 clk from second byte).
- Maximum rate one pixel per two clocks; `pixel`/`x`/`y` hold between strobes.
- `frame_done` asserts the cycle after `vsync` is first sampled high; same edge as any state change to `VBLANK`.
- `href` falling and `vsync` rising in the same cycle: row increment suppressed, frame-end handling wins.
- Reset asserted mid-line: outputs clear immediately (async); after release, state `SYNC`, no pixel until a full vsync high->low transition.

## Configuration
- `CAPTURE_STARTUP_SKIP_EN` defined: after reset the first `SKIP_FRAMES` complete frames are framed and counted but produce no `pixel_valid` and no `frame_done`; `line_err` still tracked. Counter of skipped frames is 2 bits wide minimum, saturating.
- Not defined: the first frame after `SYNC` is emitted; `SKIP_FRAMES` ignored.

## Test plan
- Reset, one 4x2 frame (`H_ACTIVE`=4, `V_ACTIVE`=2), bytes `0x0A,0xBC` per pixel -> 8 strobes, `pixel`=0xABC, (x,y) sequence (0,0)..(3,1), one `frame_done` on next vsync rise.
- Reset released mid-line with href high -> zero strobes until vsync high then low; next frame captured fully.
- Line with 7 bytes -> 3 pixels emitted, `line_err`=1, held through frame, cleared on next vsync fall.
- Line with 10 pixels at `H_ACTIVE`=4 -> exactly 4 strobes, x 0..3; third line at `V_ACTIVE`=2 -> no strobes.
- vsync rising during `BYTE1` -> no strobe for partial pixel, `frame_done` pulses once, state `VBLANK`.
- With `CAPTURE_STARTUP_SKIP_EN`, `SKIP_FRAMES`=2 -> frames 1-2 produce no strobes/`frame_done`; frame 3 produces full 8 strobes.
